// File: rtl/csa_accum_sequencer_pkg.sv
// csa_accum_sequencer_pkg: shared state encoding and default widths for the
// CSA accumulation sequencer.
package csa_accum_sequencer_pkg;

    localparam int XLEN_DEF  = 49;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_accum_sequencer_if.sv
// csa_accum_sequencer_if: job control, operand-pair and result handshakes of
// the CSA accumulation sequencer. The sequencer is the slave side.
interface csa_accum_sequencer_if
    import csa_accum_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start_i;
    logic [CNT_W-1:0] num_pairs_i;
    logic             busy_o;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  op_a_i;
    logic [XLEN-1:0]  op_b_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  sum_o;
    logic [XLEN-1:0]  carry_o;
    logic             ovf_o;

    modport slave (
        input  start_i, num_pairs_i, in_valid_i, op_a_i, op_b_i, out_ready_i,
        output busy_o, in_ready_o, out_valid_o, sum_o, carry_o, ovf_o
    );

    modport master (
        output start_i, num_pairs_i, in_valid_i, op_a_i, op_b_i, out_ready_i,
        input  busy_o, in_ready_o, out_valid_o, sum_o, carry_o, ovf_o
    );
endinterface

// File: rtl/csa_accum_sequencer_compressor42.sv
// csa_accum_sequencer_compressor42: bit-parallel 4:2 compressor built from two
// chained full-adder rows. carry has weight 2^(i+1) and is not pre-shifted;
// hidden_msb is the inter-row carry that falls off the top bit.
module csa_accum_sequencer_compressor42 #(
    parameter int XLEN = 49
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] c,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] sum,
    output logic [XLEN-1:0] carry,
    output logic            hidden_msb
);
    logic [XLEN-1:0] row_sum;
    logic [XLEN-1:0] row_carry;
    logic [XLEN-1:0] row_cin;

    // First row compresses a, b, c; its carries ripple one bit into the second row.
    assign row_sum   = a ^ b ^ c;
    assign row_carry = (a & b) | (a & c) | (b & c);
    assign row_cin   = {row_carry[XLEN-2:0], 1'b0};

    // Second row folds in d and the first-row carries.
    assign sum        = row_sum ^ d ^ row_cin;
    assign carry      = (row_sum & d) | (row_sum & row_cin) | (d & row_cin);
    assign hidden_msb = row_carry[XLEN-1];
endmodule

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: folds a stream of operand pairs into a redundant
// sum/carry accumulator through one shared 4:2 compressor, counting the job
// down and keeping a sticky flag for carries dropped at the MSB.
// Optional macro CSA_SEQ_RESOLVE_EN adds a one-cycle carry-propagate RESOLVE
// pass so the result leaves non-redundant (carry_o = 0).
module csa_accum_sequencer
    import csa_accum_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    csa_accum_sequencer_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  s_q;
    logic [XLEN-1:0]  c_q;
    logic [CNT_W-1:0] rem_q;
    logic             ovf_q;

    logic             in_ready;
    logic             out_valid;
    logic             clear;
    logic             fire;

    logic [XLEN-1:0]  cmp_sum;
    logic [XLEN-1:0]  cmp_carry;
    logic             cmp_hidden;

`ifdef CSA_SEQ_RESOLVE_EN
    localparam state_t FINISH = RESOLVE;
    logic [XLEN:0]    resolved;
    assign resolved = {1'b0, s_q} + {1'b0, c_q};
`else
    localparam state_t FINISH = DONE;
`endif

    csa_accum_sequencer_compressor42 #(.XLEN(XLEN)) u_compressor (
        .a          (bus.op_a_i),
        .b          (bus.op_b_i),
        .c          (s_q),
        .d          (c_q),
        .sum        (cmp_sum),
        .carry      (cmp_carry),
        .hidden_msb (cmp_hidden)
    );

    assign fire = in_ready & bus.in_valid_i;

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake decode; ready/valid depend on state only.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    clear     = 1'b1;
                    state_nxt = (bus.num_pairs_i == '0) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid_i && rem_q == CNT_W'(1)) state_nxt = FINISH;
            end
            RESOLVE: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, pair counter and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q   <= '0;
            c_q   <= '0;
            rem_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            s_q   <= '0;
            c_q   <= '0;
            rem_q <= bus.num_pairs_i;
            ovf_q <= 1'b0;
        end else if (fire) begin
            // Carry is stored pre-shifted so it feeds the compressor at its true weight.
            s_q   <= cmp_sum;
            c_q   <= {cmp_carry[XLEN-2:0], 1'b0};
            rem_q <= rem_q - CNT_W'(1);
            ovf_q <= ovf_q | cmp_hidden | cmp_carry[XLEN-1];
`ifdef CSA_SEQ_RESOLVE_EN
        end else if (state == RESOLVE) begin
            s_q   <= resolved[XLEN-1:0];
            c_q   <= '0;
            ovf_q <= ovf_q | resolved[XLEN];
`endif
        end
    end

    assign bus.busy_o      = (state != IDLE);
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.sum_o       = out_valid ? s_q : '0;
    assign bus.carry_o     = out_valid ? c_q : '0;
    assign bus.ovf_o       = out_valid & ovf_q;
endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer: directed bench with a result scoreboard. One DUT at
// XLEN=49 runs the main jobs, a second at XLEN=8 exercises MSB overflow.
module tb_csa_accum_sequencer;
    localparam int XW = 49;
    localparam int XS = 8;
    localparam int CW = 4;

`ifdef CSA_SEQ_RESOLVE_EN
    localparam logic [63:0] S_5_7   = 64'd12;
    localparam logic [63:0] C_5_7   = 64'd0;
    localparam logic [63:0] S_255_1 = 64'd0;
    localparam logic [63:0] C_255_1 = 64'd0;
    localparam logic        OVF_255_1 = 1'b1;
`else
    localparam logic [63:0] S_5_7   = 64'd8;
    localparam logic [63:0] C_5_7   = 64'd4;
    localparam logic [63:0] S_255_1 = 64'hFC;
    localparam logic [63:0] C_255_1 = 64'h04;
    localparam logic        OVF_255_1 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_accum_sequencer_if #(.XLEN(XW), .CNT_W(CW)) bus ();
    csa_accum_sequencer_if #(.XLEN(XS), .CNT_W(CW)) bus8 ();

    csa_accum_sequencer #(.XLEN(XW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    csa_accum_sequencer #(.XLEN(XS), .CNT_W(CW)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8)
    );

    typedef struct {
        logic [63:0] total;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t q49[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: compare every accepted result against the queue head.
    logic [XW-1:0] r49;
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            check("q49_nonempty", 64'(q49.size() != 0), 64'd1);
            if (q49.size() != 0) begin
                exp_t e;
                e   = q49.pop_front();
                r49 = bus.sum_o + bus.carry_o;
                check({e.name, "_result"}, 64'(r49), e.total);
                check({e.name, "_ovf"}, 64'(bus.ovf_o), 64'(e.ovf));
`ifdef CSA_SEQ_RESOLVE_EN
                check({e.name, "_carry_zero"}, 64'(bus.carry_o), 64'd0);
`endif
            end
        end
    end

    logic [XS-1:0] r8;
    always @(negedge clk) begin
        if (!rst && bus8.out_valid_o && bus8.out_ready_i) begin
            check("q8_nonempty", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e  = q8.pop_front();
                r8 = bus8.sum_o + bus8.carry_o;
                check({e.name, "_result"}, 64'(r8), e.total);
                check({e.name, "_ovf"}, 64'(bus8.ovf_o), 64'(e.ovf));
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic start_job(input logic [CW-1:0] n);
        bus.start_i     = 1'b1;
        bus.num_pairs_i = n;
        @(posedge clk); #1;
        bus.start_i     = 1'b0;
    endtask

    task automatic send_pair(input logic [XW-1:0] a, input logic [XW-1:0] b, input int gap);
        int n;
        bus.in_valid_i = 1'b1;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pair_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("gap_in_ready", 64'(bus.in_ready_o), 64'd1);
            check("gap_busy", 64'(bus.busy_o), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    // Ends on the falling edge of the first DONE cycle.
    task automatic check_latency(input string name);
`ifdef CSA_SEQ_RESOLVE_EN
        @(negedge clk);
        check({name, "_resolve_no_valid"}, 64'(bus.out_valid_o), 64'd0);
`endif
        @(negedge clk);
        check({name, "_latency_valid"}, 64'(bus.out_valid_o), 64'd1);
        check({name, "_latency_busy"}, 64'(bus.busy_o), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [XS-1:0] a, input logic [XS-1:0] b,
                        input logic [63:0] s_exp, input logic [63:0] c_exp, input string name);
        bus8.start_i     = 1'b1;
        bus8.num_pairs_i = 4'd1;
        @(posedge clk); #1;
        bus8.start_i     = 1'b0;
        bus8.in_valid_i  = 1'b1;
        bus8.op_a_i      = a;
        bus8.op_b_i      = b;
        @(negedge clk);
        check({name, "_ready"}, 64'(bus8.in_ready_o), 64'd1);
        @(posedge clk); #1;
        bus8.in_valid_i  = 1'b0;
`ifdef CSA_SEQ_RESOLVE_EN
        @(negedge clk);
        check({name, "_resolve_no_valid"}, 64'(bus8.out_valid_o), 64'd0);
`endif
        @(negedge clk);
        check({name, "_valid"}, 64'(bus8.out_valid_o), 64'd1);
        check({name, "_sum"}, 64'(bus8.sum_o), s_exp);
        check({name, "_carry"}, 64'(bus8.carry_o), c_exp);
        @(negedge clk);
        check({name, "_idle"}, 64'(bus8.busy_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;  bus.num_pairs_i = '0; bus.in_valid_i = 1'b0;
        bus.op_a_i = '0;     bus.op_b_i = '0;      bus.out_ready_i = 1'b1;
        bus8.start_i = 1'b0; bus8.num_pairs_i = '0; bus8.in_valid_i = 1'b0;
        bus8.op_a_i = '0;    bus8.op_b_i = '0;      bus8.out_ready_i = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_sum", 64'(bus.sum_o), 64'd0);
        check("rst_carry", 64'(bus.carry_o), 64'd0);
        check("rst_ovf", 64'(bus.ovf_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single pair (5,7): valid one cycle after the handshake.
        q49.push_back('{64'd12, 1'b0, "job1"});
        start_job(4'd1);
        send_pair(49'd5, 49'd7, 0);
        check_latency("job1");
        wait_idle("job1");

        // Three pairs with two-cycle gaps; ready and busy hold throughout.
        q49.push_back('{64'd21, 1'b0, "job3"});
        start_job(4'd3);
        send_pair(49'd1, 49'd2, 2);
        send_pair(49'd3, 49'd4, 2);
        send_pair(49'd5, 49'd6, 0);
        check_latency("job3");
        wait_idle("job3");

        // Result held under back-pressure with start pulsed, including the accept cycle.
        bus.out_ready_i = 1'b0;
        q49.push_back('{64'd12, 1'b0, "hold"});
        start_job(4'd1);
        send_pair(49'd5, 49'd7, 0);
        check_latency("hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.start_i     = 1'b1;
            bus.num_pairs_i = 4'd3;
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("hold_sum", 64'(bus.sum_o), S_5_7);
            check("hold_carry", 64'(bus.carry_o), C_5_7);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("hold_after_accept_busy", 64'(bus.busy_o), 64'd0);
        check("hold_after_accept_valid", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_start_ignored", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;

        // Zero-pair job: no input handshake, zero result.
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.op_a_i      = 49'd99;
        bus.op_b_i      = 49'd99;
        q49.push_back('{64'd0, 1'b0, "zero"});
        start_job(4'd0);
`ifdef CSA_SEQ_RESOLVE_EN
        @(negedge clk);
        check("zero_resolve_no_valid", 64'(bus.out_valid_o), 64'd0);
        check("zero_resolve_no_ready", 64'(bus.in_ready_o), 64'd0);
`endif
        @(negedge clk);
        check("zero_valid", 64'(bus.out_valid_o), 64'd1);
        check("zero_no_ready", 64'(bus.in_ready_o), 64'd0);
        check("zero_sum", 64'(bus.sum_o), 64'd0);
        check("zero_carry", 64'(bus.carry_o), 64'd0);
        @(posedge clk); #1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        wait_idle("zero");

        // Asynchronous reset after 2 of 4 pairs, with a pair in flight.
        start_job(4'd4);
        send_pair(49'd1, 49'd1, 0);
        send_pair(49'd2, 49'd2, 0);
        bus.in_valid_i = 1'b1;
        bus.op_a_i     = 49'd3;
        bus.op_b_i     = 49'd3;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("arst_sum", 64'(bus.sum_o), 64'd0);
        check("arst_carry", 64'(bus.carry_o), 64'd0);
        check("arst_ovf", 64'(bus.ovf_o), 64'd0);
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q49.push_back('{64'd10, 1'b0, "after_rst"});
        start_job(4'd1);
        send_pair(49'd9, 49'd1, 0);
        check_latency("after_rst");
        wait_idle("after_rst");

        // Narrow datapath: carries dropped at the MSB.
        q8.push_back('{64'd0, 1'b1, "p128_128"});
        run8(8'd128, 8'd128, 64'd0, 64'd0, "p128_128");
        check("p128_ovf_direct", 64'(bus8.ovf_o), 64'd0);
        q8.push_back('{64'd0, OVF_255_1, "p255_1"});
        run8(8'd255, 8'd1, S_255_1, C_255_1, "p255_1");

        @(negedge clk);
        check("q49_drained", 64'(q49.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
